// File: rtl/despachador_cubos_if.sv
// Cube-slot bus between the dispatcher and the falling-cube array.
// master = dispatcher side, slave = cube array side.
interface despachador_cubos_if #(
  parameter int NUM_CUBOS = 4
);
  logic [NUM_CUBOS-1:0] ocupado;
  logic [NUM_CUBOS-1:0] recogido;
  logic [NUM_CUBOS-1:0] perdido;
  logic [NUM_CUBOS-1:0] start_cubo;
  logic [8:0]           posicion_x_inicial;
  logic [1:0]           velocidad_cubo;
  logic [7:0]           color_cubo;

  modport master (
    input  ocupado,
    input  recogido,
    input  perdido,
    output start_cubo,
    output posicion_x_inicial,
    output velocidad_cubo,
    output color_cubo
  );

  modport slave (
    output ocupado,
    output recogido,
    output perdido,
    input  start_cubo,
    input  posicion_x_inicial,
    input  velocidad_cubo,
    input  color_cubo
  );
endinterface

// File: rtl/despachador_cubos.sv
// Cube dispatcher: LFSR launches, scoring and win/loss control.
// Optional macro DIFICULTAD_PROGRESIVA_EN shortens the spawn interval with score.
module despachador_cubos #(
  parameter int          NUM_CUBOS    = 4,
  parameter int          SPAWN_FRAMES = 60,
  parameter int          X_MAX        = 440,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          META_PUNTOS  = 20,
  parameter int          MAX_PERDIDOS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_juego,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  despachador_cubos_if.master cubos,
  output logic [7:0]  puntaje,
  output logic [3:0]  perdidos,
  output logic [1:0]  estado_juego
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JUGANDO = 2'd1,
    GANADO  = 2'd2,
    PERDIDO = 2'd3
  } estado_t;

  estado_t estado, estado_sig;
  logic    reiniciar;

  logic [15:0] lfsr;
  logic        fb;
  logic        pulso_frame;
  logic [15:0] contador;
  logic [15:0] intervalo;
  logic        fin_intervalo;
  logic        pendiente;

  logic [NUM_CUBOS-1:0] libre;
  logic [NUM_CUBOS-1:0] libre_oh;
  logic                 hay_libre;

  logic [8:0] pc_rec;
  logic [8:0] pc_per;
  logic [8:0] suma_p;
  logic [8:0] suma_l;
  logic [7:0] puntaje_sat;
  logic [3:0] perdidos_sat;

  // Payload packed as {x[8:0], vel[1:0], color[7:0]}
  function automatic logic [18:0] carga(input logic [15:0] l);
    logic [8:0] x;
    logic [1:0] v;
    logic [7:0] c;
    x = l[8:0];
    if (x > 9'(X_MAX))
      x = x - 9'(X_MAX + 1);
    v = (l[10:9] == 2'd0) ? 2'd1 : l[10:9];
    c = (l[15:8] == 8'h00) ? 8'hFF : l[15:8];
    return {x, v, c};
  endfunction

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign pulso_frame = (pixel_y == 10'd481) && (pixel_x == 10'd0);
  assign estado_juego = estado;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], fb};
  end

  // Lowest-index free slot
  assign libre     = ~cubos.ocupado;
  assign libre_oh  = libre & (~libre + NUM_CUBOS'(1));
  assign hay_libre = |libre;

  always_comb begin
    pc_rec = '0;
    pc_per = '0;
    for (int i = 0; i < NUM_CUBOS; i++) begin
      pc_rec = pc_rec + 9'(cubos.recogido[i]);
      pc_per = pc_per + 9'(cubos.perdido[i]);
    end
    suma_p = {1'b0, puntaje} + pc_rec;
    suma_l = {5'd0, perdidos} + pc_per;
    puntaje_sat  = suma_p[8] ? 8'hFF : suma_p[7:0];
    perdidos_sat = (suma_l > 9'd15) ? 4'hF : suma_l[3:0];
  end

`ifdef DIFICULTAD_PROGRESIVA_EN
  logic [15:0] reduccion;
  assign reduccion = {9'd0, puntaje[7:3], 2'b00};
  assign intervalo =
    (16'(SPAWN_FRAMES) >= 16'd16 + reduccion) ?
    16'(SPAWN_FRAMES) - reduccion : 16'd16;
`else
  assign intervalo = 16'(SPAWN_FRAMES);
`endif

  // >= so a shrinking interval still wraps cleanly
  assign fin_intervalo = (contador >= intervalo - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= IDLE;
    else          estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    reiniciar  = 1'b0;
    unique case (estado)
      IDLE, GANADO, PERDIDO: begin
        if (start_juego) begin
          estado_sig = JUGANDO;
          reiniciar  = 1'b1;
        end
      end
      JUGANDO: begin
        if (puntaje >= 8'(META_PUNTOS))
          estado_sig = GANADO;
        else if (perdidos >= 4'(MAX_PERDIDOS))
          estado_sig = PERDIDO;
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      puntaje          <= '0;
      perdidos         <= '0;
      contador         <= '0;
      pendiente        <= 1'b0;
      cubos.start_cubo <= '0;
      {cubos.posicion_x_inicial,
       cubos.velocidad_cubo,
       cubos.color_cubo} <= carga(LFSR_SEED);
    end else begin
      cubos.start_cubo <= '0;
      if (reiniciar) begin
        puntaje   <= '0;
        perdidos  <= '0;
        contador  <= '0;
        pendiente <= 1'b0;
      end else if (estado == JUGANDO) begin
        puntaje  <= puntaje_sat;
        perdidos <= perdidos_sat;
        if (pendiente && hay_libre) begin
          cubos.start_cubo <= libre_oh;
          {cubos.posicion_x_inicial,
           cubos.velocidad_cubo,
           cubos.color_cubo} <= carga(lfsr);
          pendiente <= 1'b0;
        end
        // A fresh wrap re-arms even if a launch clears it this cycle
        if (pulso_frame) begin
          if (fin_intervalo) begin
            contador  <= '0;
            pendiente <= 1'b1;
          end else begin
            contador <= contador + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_despachador_cubos.sv
// Directed bench for despachador_cubos.
// Fast spawn/goal instance plus two seed instances for payload corners.
module tb_despachador_cubos;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_juego;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [7:0] puntaje, puntaje2, puntaje3;
  logic [3:0] perdidos, perdidos2, perdidos3;
  logic [1:0] estado, estado2, estado3;

  int total = 0;
  int bad   = 0;
  int pulsos = 0;
  logic [3:0] ultimo = '0;

  despachador_cubos_if #(.NUM_CUBOS(4)) cb ();
  despachador_cubos_if #(.NUM_CUBOS(4)) c2 ();
  despachador_cubos_if #(.NUM_CUBOS(4)) c3 ();

  assign c2.ocupado  = '0;
  assign c2.recogido = '0;
  assign c2.perdido  = '0;
  assign c3.ocupado  = '0;
  assign c3.recogido = '0;
  assign c3.perdido  = '0;

  despachador_cubos #(
    .NUM_CUBOS(4), .SPAWN_FRAMES(2), .META_PUNTOS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_juego(start_juego),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cubos(cb),
    .puntaje(puntaje), .perdidos(perdidos), .estado_juego(estado)
  );

  despachador_cubos #(.LFSR_SEED(16'h01F0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start_juego(1'b0),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cubos(c2),
    .puntaje(puntaje2), .perdidos(perdidos2), .estado_juego(estado2)
  );

  despachador_cubos #(.LFSR_SEED(16'h0005)) dut3 (
    .clk(clk), .reset_n(reset_n), .start_juego(1'b0),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cubos(c3),
    .puntaje(puntaje3), .perdidos(perdidos3), .estado_juego(estado3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cb.start_cubo != 4'b0000) begin
      pulsos <= pulsos + 1;
      ultimo <= cb.start_cubo;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    pixel_y = 10'd481;
    pixel_x = 10'd0;
    tick();
    pixel_y = 10'd0;
  endtask

  initial begin
    int p0;
    int n;
    reset_n     = 1'b0;
    start_juego = 1'b0;
    pixel_x     = 10'd0;
    pixel_y     = 10'd0;
    cb.ocupado  = '0;
    cb.recogido = '0;
    cb.perdido  = '0;
    repeat (3) tick();

    check("rst_estado", 32'(estado), 0);
    check("rst_start", 32'(cb.start_cubo), 0);
    check("rst_puntaje", 32'(puntaje), 0);
    check("rst_perdidos", 32'(perdidos), 0);
    check("rst_x", 32'(cb.posicion_x_inicial), 225);
    check("rst_vel", 32'(cb.velocidad_cubo), 2);
    check("rst_color", 32'(cb.color_cubo), 32'hAC);
    check("seed2_x_fold", 32'(c2.posicion_x_inicial), 55);
    check("seed2_vel0", 32'(c2.velocidad_cubo), 1);
    check("seed2_color", 32'(c2.color_cubo), 1);
    check("seed3_x", 32'(c3.posicion_x_inicial), 5);
    check("seed3_vel0", 32'(c3.velocidad_cubo), 1);
    check("seed3_color0", 32'(c3.color_cubo), 32'hFF);

    reset_n = 1'b1;
    tick();
    check("idle_hold", 32'(estado), 0);
    start_juego = 1'b1;
    tick();
    start_juego = 1'b0;
    check("start_jugando", 32'(estado), 1);

    frame();
    check("frame1_no_launch", 32'(cb.start_cubo), 0);
    frame();
    check("frame2_pend", 32'(cb.start_cubo), 0);
    tick();
    check("launch_slot0", 32'(cb.start_cubo), 32'b0001);
    tick();
    check("launch_1cycle", 32'(cb.start_cubo), 0);

    cb.ocupado = 4'b0001;
    frame();
    frame();
    tick();
    check("launch_slot1", 32'(cb.start_cubo), 32'b0010);

    cb.ocupado = 4'b1111;
    tick();
    p0 = pulsos;
    repeat (6) begin
      frame();
      tick();
    end
    check("full_no_launch", 32'(pulsos - p0), 0);
    cb.ocupado = 4'b1011;
    p0 = pulsos;
    repeat (5) tick();
    check("no_burst", 32'(pulsos - p0), 1);
    check("launch_slot2", 32'(ultimo), 32'b0100);

    cb.ocupado  = 4'b1111;
    cb.recogido = 4'b0101;
    tick();
    cb.recogido = 4'b0000;
    check("score_pair", 32'(puntaje), 2);
    tick();
    check("ganado", 32'(estado), 2);
    cb.ocupado = 4'b0000;
    p0 = pulsos;
    repeat (4) frame();
    tick();
    check("ganado_no_launch", 32'(pulsos - p0), 0);
    cb.recogido = 4'b0001;
    tick();
    cb.recogido = 4'b0000;
    check("ganado_frozen", 32'(puntaje), 2);

    cb.ocupado  = 4'b1111;
    start_juego = 1'b1;
    tick();
    start_juego = 1'b0;
    check("restart_g_estado", 32'(estado), 1);
    check("restart_g_puntaje", 32'(puntaje), 0);
    cb.recogido = 4'b0001;
    tick();
    cb.recogido = 4'b0000;
    start_juego = 1'b1;
    tick();
    start_juego = 1'b0;
    check("start_ignored_est", 32'(estado), 1);
    check("start_ignored_pts", 32'(puntaje), 1);

    cb.perdido = 4'b0011;
    tick();
    check("miss_pair", 32'(perdidos), 2);
    cb.perdido = 4'b0001;
    tick();
    cb.perdido = 4'b0011;
    tick();
    cb.perdido = 4'b0000;
    check("miss_five", 32'(perdidos), 5);
    tick();
    check("perdido", 32'(estado), 3);
    cb.perdido = 4'b0001;
    tick();
    cb.perdido = 4'b0000;
    check("perdido_frozen", 32'(perdidos), 5);

    start_juego = 1'b1;
    tick();
    start_juego = 1'b0;
    check("restart_p_estado", 32'(estado), 1);
    check("restart_p_perd", 32'(perdidos), 0);
    check("restart_p_pts", 32'(puntaje), 0);

    cb.ocupado = 4'b0000;
    frame();
    frame();
    tick();
    check("pre_reset_launch", 32'(cb.start_cubo), 32'b0001);
    reset_n = 1'b0;
    #1;
    check("async_rst_start", 32'(cb.start_cubo), 0);
    check("async_rst_estado", 32'(estado), 0);
    tick();
    reset_n = 1'b1;
    tick();

    pixel_y = 10'd481;
    pixel_x = 10'd0;
    start_juego = 1'b1;
    tick();
    start_juego = 1'b0;
    n = 0;
    for (int c = 0; c < 40000 && n < 10000; c++) begin
      tick();
      if (cb.start_cubo != 4'b0000) begin
        n++;
        check("x_range", 32'(cb.posicion_x_inicial <= 9'd440), 1);
      end
    end
    check("launch_count", 32'(n), 10000);
    pixel_y = 10'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
